// File: rtl/uart_link_pkg.sv
// Shared types and helpers for the uart_link block.
// Optional parity support is enabled by defining UART_LINK_PARITY_EN.
package uart_link_pkg;

   typedef enum logic [2:0] {
      TX_GUARD,
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_t;

   localparam int SYNC_STAGES = 2;

   // Callers zero-extend their payload; extra zeros do not change the XOR.
   function automatic logic even_parity(input logic [15:0] bits);
      return ^bits;
   endfunction

endpackage

// File: rtl/uart_link_baud.sv
// Reloadable bit-period down-counter; tick is high while the count is zero.
module uart_link_baud #(
   parameter int CLK_DIV = 434
) (
   input  logic clk,
   input  logic nrst,
   input  logic load_full,
   input  logic load_half,
   output logic tick
);

   localparam int CW = $clog2(CLK_DIV);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         cnt_q <= '0;
      else if (load_full)
         cnt_q <= CW'(CLK_DIV - 1);
      else if (load_half)
         cnt_q <= CW'(CLK_DIV / 2 - 1);
      else if (cnt_q != '0)
         cnt_q <= cnt_q - CW'(1);
   end

   assign tick = (cnt_q == '0);

endmodule

// File: rtl/uart_link.sv
// Full-duplex UART with TX guard period and mid-bit sampling receiver.
// Define UART_LINK_PARITY_EN to add an even-parity bit on both directions.
module uart_link
   import uart_link_pkg::*;
#(
   parameter int CLK_DIV      = 434,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1,
   parameter int GUARD_CYCLES = 511
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic                 link_en,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_frame_err,
   output logic                 rx_parity_err,
   input  logic                 uart_rx,
   output logic                 uart_tx,
   output logic                 guard_done
);

   localparam int BW = $clog2(DATA_BITS + 1);

   // ---------------- guard counter ----------------
   logic [15:0] guard_cnt_q;
   logic        guard_hit;

   assign guard_hit = (guard_cnt_q == 16'(GUARD_CYCLES));

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         guard_cnt_q <= '0;
         guard_done  <= 1'b0;
      end else if (!link_en) begin
         guard_cnt_q <= '0;
         guard_done  <= 1'b0;
      end else begin
         if (!guard_hit)
            guard_cnt_q <= guard_cnt_q + 16'd1;
         guard_done <= guard_hit;
      end
   end

   // ---------------- transmitter ----------------
   tx_state_t            tx_state_q, tx_state_d;
   logic [DATA_BITS-1:0] tx_shreg_q, tx_shreg_d;
   logic [BW-1:0]        tx_bit_q, tx_bit_d;
   logic                 tx_par_q, tx_par_d;
   logic                 tx_line_d, tx_ready_d;
   logic                 tx_load, tx_tick;

   uart_link_baud #(.CLK_DIV(CLK_DIV)) u_tx_baud (
      .clk       (clk),
      .nrst      (nrst),
      .load_full (tx_load),
      .load_half (1'b0),
      .tick      (tx_tick)
   );

   always_comb begin
      tx_state_d = tx_state_q;
      tx_shreg_d = tx_shreg_q;
      tx_bit_d   = tx_bit_q;
      tx_par_d   = tx_par_q;
      tx_load    = 1'b0;
      tx_line_d  = 1'b1;
      case (tx_state_q)
         TX_GUARD: if (guard_hit) tx_state_d = TX_IDLE;
         TX_IDLE: begin
            if (tx_valid && tx_ready) begin
               tx_state_d = TX_START;
               tx_shreg_d = tx_data;
               tx_par_d   = even_parity(16'(tx_data));
               tx_load    = 1'b1;
            end
         end
         TX_START: begin
            if (tx_tick) begin
               tx_state_d = TX_DATA;
               tx_bit_d   = '0;
               tx_load    = 1'b1;
            end
         end
         TX_DATA: begin
            if (tx_tick) begin
               tx_load = 1'b1;
               if (tx_bit_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_LINK_PARITY_EN
                  tx_state_d = TX_PARITY;
`else
                  tx_state_d = TX_STOP;
`endif
                  tx_bit_d = '0;
               end else begin
                  tx_bit_d   = tx_bit_q + BW'(1);
                  tx_shreg_d = tx_shreg_q >> 1;
               end
            end
         end
         TX_PARITY: begin
            if (tx_tick) begin
               tx_state_d = TX_STOP;
               tx_bit_d   = '0;
               tx_load    = 1'b1;
            end
         end
         TX_STOP: begin
            if (tx_tick) begin
               if (tx_bit_q == BW'(STOP_BITS - 1)) begin
                  tx_state_d = TX_IDLE;
               end else begin
                  tx_bit_d = tx_bit_q + BW'(1);
                  tx_load  = 1'b1;
               end
            end
         end
         default: tx_state_d = TX_GUARD;
      endcase

      if (!link_en) begin
         tx_state_d = TX_GUARD;
         tx_load    = 1'b0;
      end

      // Line level is decoded from the next state so uart_tx comes straight from a flop.
      case (tx_state_d)
         TX_GUARD:  tx_line_d = 1'b0;
         TX_START:  tx_line_d = 1'b0;
         TX_DATA:   tx_line_d = tx_shreg_d[0];
         TX_PARITY: tx_line_d = tx_par_d;
         default:   tx_line_d = 1'b1;
      endcase

      // Ready is raised only after a full cycle spent in IDLE.
      tx_ready_d = (tx_state_q == TX_IDLE) && (tx_state_d == TX_IDLE);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         tx_state_q <= TX_GUARD;
         tx_shreg_q <= '0;
         tx_bit_q   <= '0;
         tx_par_q   <= 1'b0;
         uart_tx    <= 1'b0;
         tx_ready   <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_shreg_q <= tx_shreg_d;
         tx_bit_q   <= tx_bit_d;
         tx_par_q   <= tx_par_d;
         uart_tx    <= tx_line_d;
         tx_ready   <= tx_ready_d;
      end
   end

   // ---------------- receiver ----------------
   logic [SYNC_STAGES-1:0] rx_sync_q;
   logic                   rx_s, rx_prev_q;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rx_sync_q <= '1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_sync_q <= {rx_sync_q[SYNC_STAGES-2:0], uart_rx};
         rx_prev_q <= rx_s;
      end
   end

   assign rx_s = rx_sync_q[SYNC_STAGES-1];

   rx_state_t            rx_state_q, rx_state_d;
   logic [DATA_BITS-1:0] rx_shreg_q, rx_shreg_d, rx_data_d;
   logic [BW-1:0]        rx_bit_q, rx_bit_d;
   logic                 rx_valid_d, rx_frame_err_d;
   logic                 rx_load_full, rx_load_half, rx_tick;
`ifdef UART_LINK_PARITY_EN
   logic                 rx_par_q, rx_par_d, rx_par_err_d;
`endif

   uart_link_baud #(.CLK_DIV(CLK_DIV)) u_rx_baud (
      .clk       (clk),
      .nrst      (nrst),
      .load_full (rx_load_full),
      .load_half (rx_load_half),
      .tick      (rx_tick)
   );

   always_comb begin
      rx_state_d     = rx_state_q;
      rx_shreg_d     = rx_shreg_q;
      rx_bit_d       = rx_bit_q;
      rx_data_d      = rx_data;
      rx_valid_d     = 1'b0;
      rx_frame_err_d = 1'b0;
      rx_load_full   = 1'b0;
      rx_load_half   = 1'b0;
`ifdef UART_LINK_PARITY_EN
      rx_par_d       = rx_par_q;
      rx_par_err_d   = 1'b0;
`endif
      case (rx_state_q)
         RX_IDLE: begin
            if (!rx_s && rx_prev_q) begin
               rx_state_d   = RX_START;
               rx_load_half = 1'b1;
            end
         end
         RX_START: begin
            if (rx_tick) begin
               if (rx_s) begin
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_state_d   = RX_DATA;
                  rx_bit_d     = '0;
                  rx_load_full = 1'b1;
               end
            end
         end
         RX_DATA: begin
            if (rx_tick) begin
               rx_load_full = 1'b1;
               rx_shreg_d   = {rx_s, rx_shreg_q[DATA_BITS-1:1]};
               if (rx_bit_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_LINK_PARITY_EN
                  rx_state_d = RX_PARITY;
`else
                  rx_state_d = RX_STOP;
`endif
               end else begin
                  rx_bit_d = rx_bit_q + BW'(1);
               end
            end
         end
         RX_PARITY: begin
            if (rx_tick) begin
`ifdef UART_LINK_PARITY_EN
               rx_par_d = rx_s;
`endif
               rx_state_d   = RX_STOP;
               rx_load_full = 1'b1;
            end
         end
         RX_STOP: begin
            if (rx_tick) begin
               rx_state_d     = RX_IDLE;
               rx_data_d      = rx_shreg_q;
               rx_valid_d     = 1'b1;
               rx_frame_err_d = !rx_s;
`ifdef UART_LINK_PARITY_EN
               rx_par_err_d   = rx_par_q ^ even_parity(16'(rx_shreg_q));
`endif
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase

      if (!link_en) begin
         rx_state_d     = RX_IDLE;
         rx_data_d      = rx_data;
         rx_valid_d     = 1'b0;
         rx_frame_err_d = 1'b0;
         rx_load_full   = 1'b0;
         rx_load_half   = 1'b0;
`ifdef UART_LINK_PARITY_EN
         rx_par_err_d   = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rx_state_q   <= RX_IDLE;
         rx_shreg_q   <= '0;
         rx_bit_q     <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
      end else begin
         rx_state_q   <= rx_state_d;
         rx_shreg_q   <= rx_shreg_d;
         rx_bit_q     <= rx_bit_d;
         rx_data      <= rx_data_d;
         rx_valid     <= rx_valid_d;
         rx_frame_err <= rx_frame_err_d;
      end
   end

`ifdef UART_LINK_PARITY_EN
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rx_par_q      <= 1'b0;
         rx_parity_err <= 1'b0;
      end else begin
         rx_par_q      <= rx_par_d;
         rx_parity_err <= rx_par_err_d;
      end
   end
`else
   assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_link.sv
// Randomised self-checking bench for uart_link against a frame-level model.
// Honours UART_LINK_PARITY_EN the same way the design does.
module tb_uart_link;

   localparam int CD    = 434;
   localparam int DB    = 8;
   localparam int SB    = 1;
   localparam int GUARD = 511;
`ifdef UART_LINK_PARITY_EN
   localparam int PAR   = 1;
`else
   localparam int PAR   = 0;
`endif
   localparam int NB    = 1 + DB + PAR + SB;

   logic          clk = 1'b0;
   logic          nrst = 1'b0;
   logic          link_en = 1'b1;
   logic [DB-1:0] tx_data = '0;
   logic          tx_valid = 1'b0;
   logic          tx_ready;
   logic [DB-1:0] rx_data;
   logic          rx_valid, rx_frame_err, rx_parity_err;
   logic          uart_tx, guard_done;
   logic          rx_drive = 1'b1;
   logic          loop_en = 1'b0;
   logic          uart_rx;

   assign uart_rx = loop_en ? uart_tx : rx_drive;

   always #5 clk = ~clk;

   uart_link #(
      .CLK_DIV      (CD),
      .DATA_BITS    (DB),
      .STOP_BITS    (SB),
      .GUARD_CYCLES (GUARD)
   ) dut (
      .clk           (clk),
      .nrst          (nrst),
      .link_en       (link_en),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_frame_err  (rx_frame_err),
      .rx_parity_err (rx_parity_err),
      .uart_rx       (uart_rx),
      .uart_tx       (uart_tx),
      .guard_done    (guard_done)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Receive monitor: every rx_valid pulse becomes an event; stray flag pulses are counted.
   typedef struct { logic [DB-1:0] d; logic fe; logic pe; } rx_ev_t;
   rx_ev_t rx_q[$];
   int     stray_flags = 0;

   always @(negedge clk) begin
      if (nrst && rx_valid) rx_q.push_back('{rx_data, rx_frame_err, rx_parity_err});
      if (nrst && !rx_valid && (rx_frame_err || rx_parity_err)) stray_flags++;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference frame: start 0, data LSB first, even parity, stop bits 1.
   function automatic logic frame_bit(input logic [DB-1:0] d, input int i);
      if (i == 0) return 1'b0;
      if (i <= DB) return d[i-1];
      if (PAR == 1 && i == DB + 1) return ^d;
      return 1'b1;
   endfunction

   task automatic send_byte(input logic [DB-1:0] d);
      int budget = (NB + 2) * CD;
      while (!tx_ready && budget > 0) begin
         step(1);
         budget--;
      end
      check("tx_ready_wait", 32'(tx_ready), 32'd1);
      tx_data  = d;
      tx_valid = 1'b1;
      step(1);
      tx_valid = 1'b0;
   endtask

   task automatic expect_rx(input string tag, input logic [DB-1:0] d, input logic fe, input logic pe);
      rx_ev_t ev;
      int budget = 2 * NB * CD;
      while (rx_q.size() == 0 && budget > 0) begin
         step(1);
         budget--;
      end
      check({tag, "_present"}, 32'(rx_q.size() > 0), 32'd1);
      if (rx_q.size() > 0) begin
         ev = rx_q.pop_front();
         check({tag, "_data"}, 32'(ev.d), 32'(d));
         check({tag, "_ferr"}, 32'(ev.fe), 32'(fe));
         check({tag, "_perr"}, 32'(ev.pe), 32'(pe));
      end
   endtask

   task automatic drive_frame(input logic [DB-1:0] d, input logic stop_v, input logic par_flip);
      logic b;
      for (int i = 0; i < NB; i++) begin
         b = frame_bit(d, i);
         if (i == 1 + DB + PAR) b = stop_v;
         if (PAR == 1 && i == DB + 1) b = b ^ par_flip;
         rx_drive = b;
         step(CD);
      end
      rx_drive = 1'b1;
      step(CD);
   endtask

   // Guard period observed from the first edge after link start.
   task automatic guard_phase(input string tag);
      int low_ok = 1;
      for (int k = 1; k <= GUARD; k++) begin
         step(1);
         if (uart_tx !== 1'b0 || guard_done !== 1'b0 || tx_ready !== 1'b0) low_ok = 0;
      end
      check({tag, "_held_low"}, 32'(low_ok), 32'd1);
      step(1);
      check({tag, "_guard_done"}, 32'(guard_done), 32'd1);
      check({tag, "_tx_idle_high"}, 32'(uart_tx), 32'd1);
      check({tag, "_ready_late"}, 32'(tx_ready), 32'd0);
      step(1);
      check({tag, "_ready"}, 32'(tx_ready), 32'd1);
   endtask

   initial begin
      logic [DB-1:0] rnd[5];
      logic [DB-1:0] v;
      logic          sv;

      // Reset values
      step(3);
      check("rst_uart_tx", 32'(uart_tx), 32'd0);
      check("rst_tx_ready", 32'(tx_ready), 32'd0);
      check("rst_guard_done", 32'(guard_done), 32'd0);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_rx_ferr", 32'(rx_frame_err), 32'd0);
      check("rst_rx_perr", 32'(rx_parity_err), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'd0);
      nrst = 1'b1;
      guard_phase("guard1");

      // Transmit waveform of 0xA5 sampled at mid-bit
      send_byte(8'hA5);
      step(CD / 2);
      for (int i = 0; i < NB; i++) begin
         check($sformatf("tx_a5_bit%0d", i), 32'(uart_tx), 32'(frame_bit(8'hA5, i)));
         if (i < NB - 1) step(CD);
      end
      step(CD - CD / 2);
      check("tx_a5_ready_low_at_end", 32'(tx_ready), 32'd0);
      check("tx_a5_line_idle", 32'(uart_tx), 32'd1);
      step(1);
      check("tx_a5_ready_back", 32'(tx_ready), 32'd1);

      // Loopback, back-to-back frames
      loop_en = 1'b1;
      send_byte(8'h3C);
      send_byte(8'hFF);
      expect_rx("loop_3c", 8'h3C, 1'b0, 1'b0);
      expect_rx("loop_ff", 8'hFF, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         rnd[i] = DB'($urandom);
         send_byte(rnd[i]);
      end
      for (int i = 0; i < 5; i++) expect_rx($sformatf("loop_rnd%0d", i), rnd[i], 1'b0, 1'b0);
      step(NB * CD);
      loop_en = 1'b0;

      // Short low glitch is rejected
      step(2 * CD);
      rx_drive = 1'b0;
      step(100);
      rx_drive = 1'b1;
      step(NB * CD);
      check("glitch_no_valid", 32'(rx_q.size()), 32'd0);
      check("glitch_no_flags", 32'(stray_flags), 32'd0);

      // Bad stop bit, then random bit-banged frames
      drive_frame(8'h55, 1'b0, 1'b0);
      expect_rx("ferr_55", 8'h55, 1'b1, 1'b0);
      if (PAR == 1) begin
         drive_frame(8'h07, 1'b1, 1'b1);
         expect_rx("perr_07", 8'h07, 1'b0, 1'b1);
      end
      for (int i = 0; i < 3; i++) begin
         v  = DB'($urandom);
         sv = 1'($urandom_range(0, 1));
         drive_frame(v, sv, 1'b0);
         expect_rx($sformatf("bb_rnd%0d", i), v, !sv, 1'b0);
      end

      // Link drop mid-frame aborts both directions, guard restarts
      loop_en = 1'b1;
      send_byte(8'h96);
      step(3 * CD);
      link_en = 1'b0;
      step(1);
      check("drop_uart_tx", 32'(uart_tx), 32'd0);
      check("drop_tx_ready", 32'(tx_ready), 32'd0);
      check("drop_guard_done", 32'(guard_done), 32'd0);
      step(50);
      link_en = 1'b1;
      guard_phase("guard2");
      step(NB * CD);
      check("drop_no_partial_rx", 32'(rx_q.size()), 32'd0);
      check("end_no_stray_flags", 32'(stray_flags), 32'd0);
      loop_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_link.md
Name: uart_link

Overview:
- Parametrised full-duplex UART block for the FPGA SoC bring-up path. It is the successor to the single-line link test.
- Provides a byte transmitter with a valid/ready handshake and a receiver with a mid-bit sampler and error flags.
- Holds the TX line low for a configurable guard period after link enable, then idles it high.
- Sits between the CPU memory-mapped IO and the GPIO header pins.

Parameters:
- CLK_DIV, 434, clock cycles per bit (50 MHz / 115200 baud); must be at least 4
- DATA_BITS, 8, payload bits per frame, 5..9
- STOP_BITS, 1, stop bits transmitted, 1 or 2; RX checks only the first stop bit
- GUARD_CYCLES, 511, cycles TX is held low after link_en rises

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- link_en  in  1  link enable (board vdd/gnd sense); low forces the guard state
- tx_data  in  DATA_BITS  byte to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  transmitter accepts on tx_valid&&tx_ready
- rx_data  out  DATA_BITS  last received byte
- rx_valid  out  1  one-cycle pulse when rx_data updates
- rx_frame_err  out  1  one-cycle pulse when the stop bit samples low
- rx_parity_err  out  1  one-cycle pulse on parity mismatch (tied 0 without the parity feature)
- uart_rx  in  1  serial input (asynchronous)
- uart_tx  out  1  serial output
- guard_done  out  1  high once the guard period has elapsed

Behaviour:
- Reset (nrst=0, asynchronous):
  - uart_tx=0, tx_ready=0, guard_done=0
  - rx_valid=0, rx_frame_err=0, rx_parity_err=0, rx_data=0
  - all counters 0; both FSMs in their first state
- Guard counter (16 bits):
  - link_en=0: counter clears, uart_tx=0, guard_done=0, TX FSM forced to GUARD, RX FSM forced to IDLE.
  - link_en=1: counter increments each cycle until it reaches GUARD_CYCLES.
  - Next cycle after reaching GUARD_CYCLES: guard_done=1, TX enters IDLE, uart_tx=1.
- TX FSM states: GUARD, IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_ready=1. Handshake latches tx_data; the next cycle is START and uart_tx=0.
  - Each state lasts exactly CLK_DIV cycles, counted by a baud counter that reloads per bit.
  - DATA sends LSB first, DATA_BITS bits.
  - STOP drives 1 for STOP_BITS*CLK_DIV cycles, then returns to IDLE; tx_ready rises on the following cycle.
  - tx_ready=0 in every state except IDLE.
  - A back-to-back frame has no extra idle bit.
- RX path:
  - uart_rx passes through a 2-flop synchroniser, reset value 1.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE→START on a synchronised falling edge (the cycle's sample is 0 and the previous sample was 1).
  - START waits CLK_DIV/2 cycles, then resamples. If the line is 1, the start was a glitch: return to IDLE with no flags.
  - Otherwise sample every CLK_DIV cycles at mid-bit: DATA_BITS data bits (LSB first), an optional parity bit, then the stop bit.
  - After the stop sample, in the same cycle:
    - rx_data updates to the received byte
    - rx_valid pulses (the byte is delivered even on error)
    - rx_frame_err pulses if the stop bit was 0
    - rx_parity_err pulses on a parity mismatch
  - Then return to IDLE. A new start edge is accepted from the next cycle.
- RX is independent of the TX state, so full duplex works; it runs whenever link_en=1.
- No RX buffering: the consumer must take rx_data within one frame time.
- Dropping link_en mid-frame aborts both FSMs on the next clock. No partial rx_valid is produced.
- Arithmetic:
  - baud counter width is $clog2(CLK_DIV)
  - bit counter width is $clog2(DATA_BITS+1)
  - CLK_DIV/2 uses integer division

Optional Feature:
- Macro UART_LINK_PARITY_EN.
  - Defined: TX inserts a PARITY bit after DATA, equal to the XOR of the data bits (even parity). RX samples and checks it, driving rx_parity_err.
  - Undefined: the PARITY states are never entered and rx_parity_err is tied to 0.

Decomposition:
- Package uart_link_pkg holds:
  - the tx_state_t and rx_state_t enums
  - constant SYNC_STAGES=2
  - function even_parity()
- Natural sub-module: uart_link_baud, a reloadable down-counter with a tick output and a half-period load, instantiated once each in TX and RX.

Test Plan:
1. Reset with link_en=1 → uart_tx=0 for 511 cycles after release; guard_done=1 and uart_tx=1 on cycle 512; tx_ready=1 one cycle after that.
2. Send 0xA5 → uart_tx, sampled every 434 cycles, shows 0,1,0,1,0,0,1,0,1,1; tx_ready returns after 10*434 cycles.
3. Loop uart_tx back to uart_rx and send 0x3C then 0xFF back-to-back → two rx_valid pulses with rx_data 0x3C then 0xFF; error flags stay 0.
4. Drive a 100-cycle low glitch on uart_rx → no rx_valid and no error flags.
5. Drive frame 0x55 with the stop bit held 0 → rx_valid and rx_frame_err pulse together with rx_data=0x55. With UART_LINK_PARITY_EN defined, a wrong parity bit on 0x07 → rx_parity_err=1.
6. Drop link_en during DATA of a TX frame → uart_tx=0 and tx_ready=0 on the next cycle; the guard period restarts from 0 when link_en returns.
